mire_gen: RTL and testbench

MIRE_GEN -- requirements
Module: mire_gen

---
 rtl/mire_pkg.sv | 26 ++
 rtl/wshb_if.sv | 22 ++
 rtl/mire_pixel.sv | 33 +++
 rtl/mire_gen.sv | 134 +++++++++++++
 tb/tb_mire_gen.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mire_pkg.sv
// Shared types and constants for the test-pattern generator.
// Holds the pattern modes, the sequencer states and the colour-bar palette.
package mire_pkg;

    typedef enum logic [1:0] {
        MODE_SOLID = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_RAMP  = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic [23:0] BAR_COLORS [8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

    localparam logic [2:0] CTI_INCR = 3'b010;
    localparam logic [2:0] CTI_END  = 3'b111;

endpackage

// File: rtl/wshb_if.sv
// 32-bit Wishbone B4 bus bundle with clock and reset; the master modport drives the request side.
// Pure wiring: no latency, handshake is ack/err from the slave.
interface wshb_if (
    input logic clk,
    input logic rst
);
    logic [31:0] adr;
    logic [31:0] dat_ms;
    logic        we;
    logic        cyc;
    logic        stb;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack;
    logic        err;

    modport master (
        input  clk, rst, ack, err,
        output adr, dat_ms, we, cyc, stb, sel, cti, bte
    );
endinterface

// File: rtl/mire_pixel.sv
// Combinational (x, y, mode, color) -> 24-bit {R,G,B} pattern pixel.
// Zero latency, no flow control.
module mire_pixel
    import mire_pkg::*;
#(
    parameter int HDISP      = 800,
    parameter int CHECK_LOG2 = 4
) (
    input  logic [15:0] x_i,
    input  logic [15:0] y_i,
    input  mode_t       mode_i,
    input  logic [23:0] color_i,
    output logic [23:0] pixel_o
);
    localparam logic [15:0] BAR_W = 16'(HDISP / 8);

    logic [2:0] bar_idx;
    logic       unused_y;

    assign bar_idx  = 3'(x_i / BAR_W);
    assign unused_y = ^y_i;

    always_comb begin
        pixel_o = 24'h000000;
        case (mode_i)
            MODE_SOLID: pixel_o = color_i;
            MODE_BARS:  pixel_o = BAR_COLORS[bar_idx];
            MODE_CHECK: pixel_o = (x_i[CHECK_LOG2] ^ y_i[CHECK_LOG2]) ? 24'h000000 : color_i;
            MODE_RAMP:  pixel_o = {3{x_i[7:0]}};
            default:    pixel_o = 24'h000000;
        endcase
    end
endmodule

// File: rtl/mire_gen.sv
// Test-pattern frame writer: streams pixels as incrementing Wishbone write bursts, one GAP cycle between bursts.
// One beat per ack; a beat holds until ack without err; enable is honoured only at burst boundaries.
module mire_gen
    import mire_pkg::*;
#(
    parameter int          HDISP      = 800,
    parameter int          VDISP      = 480,
    parameter logic [31:0] BASE_ADR   = 32'h0000_0000,
    parameter int          BURST_LEN  = 8,
    parameter int          CHECK_LOG2 = 4
) (
    wshb_if.master      wshb_ifm,
    input  logic        enable,
    input  logic [1:0]  mode,
    input  logic [23:0] color,
    output logic        frame_done,
    output logic        busy
);
    if (HDISP < 8 || (HDISP % 8) != 0) begin : g_bad_hdisp
        $error("mire_gen: HDISP must be a non-zero multiple of 8");
    end
    if (BASE_ADR[1:0] != 2'b00) begin : g_bad_base
        $error("mire_gen: BASE_ADR must be 4-byte aligned");
    end
    if (BURST_LEN < 1 || (BURST_LEN & (BURST_LEN - 1)) != 0 || ((HDISP * VDISP) % BURST_LEN) != 0) begin : g_bad_burst
        $error("mire_gen: BURST_LEN must be a power of two dividing HDISP*VDISP");
    end

    localparam int             BW        = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BW-1:0]  BEAT_LAST = BW'(BURST_LEN - 1);
    localparam logic [15:0]    X_LAST    = 16'(HDISP - 1);
    localparam logic [15:0]    Y_LAST    = 16'(VDISP - 1);

    state_t        state_q, state_d;
    logic [15:0]   x_q, x_d, y_q, y_d;
    logic [31:0]   pix_q, pix_d;
    logic [BW-1:0] beat_q, beat_d;
    mode_t         fmode_q, fmode_d;
    logic [23:0]   fcolor_q, fcolor_d;
    logic          fdone_q, fdone_d;

    logic          in_burst, accept, at_origin, last_beat, last_pix;
    mode_t         pix_mode;
    logic [23:0]   pix_color, pixel;

    assign in_burst  = (state_q == ST_BURST);
    assign accept    = in_burst && wshb_ifm.ack && !wshb_ifm.err;
    assign at_origin = (x_q == 16'd0) && (y_q == 16'd0);
    assign last_beat = (beat_q == BEAT_LAST);
    assign last_pix  = (x_q == X_LAST) && (y_q == Y_LAST);

    // The origin beat already shows the new frame's settings; they are frozen once it is accepted.
    assign pix_mode  = at_origin ? mode_t'(mode) : fmode_q;
    assign pix_color = at_origin ? color : fcolor_q;

    mire_pixel #(
        .HDISP      (HDISP),
        .CHECK_LOG2 (CHECK_LOG2)
    ) u_pixel (
        .x_i     (x_q),
        .y_i     (y_q),
        .mode_i  (pix_mode),
        .color_i (pix_color),
        .pixel_o (pixel)
    );

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        pix_d    = pix_q;
        beat_d   = beat_q;
        fmode_d  = fmode_q;
        fcolor_d = fcolor_q;
        fdone_d  = 1'b0;

        case (state_q)
            ST_IDLE:  if (enable) state_d = ST_BURST;
            ST_BURST: if (accept && last_beat) state_d = ST_GAP;
            ST_GAP:   state_d = enable ? ST_BURST : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        if (accept) begin
            beat_d = last_beat ? '0 : beat_q + 1'b1;
            pix_d  = last_pix ? 32'd0 : pix_q + 32'd1;
            if (x_q == X_LAST) begin
                x_d = 16'd0;
                y_d = (y_q == Y_LAST) ? 16'd0 : y_q + 16'd1;
            end else begin
                x_d = x_q + 16'd1;
            end
            if (at_origin) begin
                fmode_d  = mode_t'(mode);
                fcolor_d = color;
            end
            fdone_d = last_pix;
        end
    end

    always_ff @(posedge wshb_ifm.clk) begin
        if (wshb_ifm.rst) begin
            state_q  <= ST_IDLE;
            x_q      <= 16'd0;
            y_q      <= 16'd0;
            pix_q    <= 32'd0;
            beat_q   <= '0;
            fmode_q  <= MODE_SOLID;
            fcolor_q <= 24'h000000;
            fdone_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            pix_q    <= pix_d;
            beat_q   <= beat_d;
            fmode_q  <= fmode_d;
            fcolor_q <= fcolor_d;
            fdone_q  <= fdone_d;
        end
    end

    assign wshb_ifm.cyc    = in_burst;
    assign wshb_ifm.stb    = in_burst;
    assign wshb_ifm.we     = 1'b1;
    assign wshb_ifm.sel    = 4'b1111;
    assign wshb_ifm.bte    = 2'b00;
    assign wshb_ifm.cti    = last_beat ? CTI_END : CTI_INCR;
    assign wshb_ifm.adr    = BASE_ADR + (pix_q << 2);
    assign wshb_ifm.dat_ms = {8'h00, pixel};

    assign frame_done = fdone_q;
    assign busy       = (state_q != ST_IDLE);
endmodule

// File: tb/tb_mire_gen.sv
// Directed bench for mire_gen on a 16x4 frame, 4-beat bursts, base 0x1000, 2-pixel checker squares.
module tb_mire_gen;
    localparam int          HD   = 16;
    localparam int          VD   = 4;
    localparam int          BL   = 4;
    localparam int          NPIX = HD * VD;
    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [23:0] color = 24'h0;
    logic        frame_done, busy;

    wshb_if wb (.clk(clk), .rst(rst));

    mire_gen #(
        .HDISP(HD), .VDISP(VD), .BASE_ADR(BASE), .BURST_LEN(BL), .CHECK_LOG2(1)
    ) dut (
        .wshb_ifm   (wb.master),
        .enable     (enable),
        .mode       (mode),
        .color      (color),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          frame;
        int          pix;
        logic [31:0] exp_dat;
    } vec_t;

    localparam int NVEC = 33;
    vec_t vecs [NVEC];

    int          n_chk = 0;
    int          n_fail = 0;
    int          cycle = 0;
    logic [31:0] cap_adr [NPIX];
    logic [31:0] cap_dat [NPIX];
    logic [2:0]  cap_cti [NPIX];
    int          cap_cyc [NPIX];

    task automatic step();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Collects one frame of accepted beats (ack held high), optionally changing mode/color mid-frame.
    task automatic run_frame(input int chg_at, input logic [1:0] nmode, input logic [23:0] ncolor,
                             output int fd_during, output logic fd_after, output logic cyc_after);
        int n = 0;
        int budget = 0;
        fd_during = 0;
        while (n < NPIX && budget < 400) begin
            if (wb.cyc && wb.stb) begin
                if (n == 0) begin
                    check("we", {31'd0, wb.we}, 32'd1);
                    check("sel", {28'd0, wb.sel}, 32'hF);
                    check("bte", {30'd0, wb.bte}, 32'd0);
                end
                cap_adr[n] = wb.adr;
                cap_dat[n] = wb.dat_ms;
                cap_cti[n] = wb.cti;
                cap_cyc[n] = cycle;
                if (n == chg_at) begin
                    mode  = nmode;
                    color = ncolor;
                end
                n++;
            end
            step();
            budget++;
            if (frame_done && n < NPIX) fd_during++;
        end
        check("frame_beats", n, NPIX);
        fd_after  = frame_done;
        cyc_after = wb.cyc;
    endtask

    task automatic check_frame(input int f);
        for (int i = 0; i < NPIX; i++) begin
            check($sformatf("f%0d_adr%0d", f, i), cap_adr[i], BASE + 32'(4 * i));
            check($sformatf("f%0d_cti%0d", f, i), {29'd0, cap_cti[i]}, (i % BL == BL - 1) ? 32'd7 : 32'd2);
            if (i > 0)
                check($sformatf("f%0d_space%0d", f, i), cap_cyc[i] - cap_cyc[i-1], (i % BL == 0) ? 32'd2 : 32'd1);
        end
        for (int v = 0; v < NVEC; v++)
            if (vecs[v].frame == f)
                check($sformatf("f%0d_pix%0d", f, vecs[v].pix), cap_dat[vecs[v].pix], vecs[v].exp_dat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int          fr_chg [4];
        logic [1:0]  fr_mode [4];
        logic [23:0] fr_color [4];
        int          fdd;
        logic        fda, cyca;
        int          guard;

        vecs[0]  = '{0, 0,  32'h00123456};
        vecs[1]  = '{0, 29, 32'h00123456};
        vecs[2]  = '{0, 40, 32'h00123456};
        vecs[3]  = '{0, 63, 32'h00123456};
        vecs[4]  = '{1, 0,  32'h00FFFFFF};
        vecs[5]  = '{1, 1,  32'h00FFFFFF};
        vecs[6]  = '{1, 2,  32'h00FFFF00};
        vecs[7]  = '{1, 5,  32'h0000FFFF};
        vecs[8]  = '{1, 6,  32'h0000FF00};
        vecs[9]  = '{1, 8,  32'h00FF00FF};
        vecs[10] = '{1, 11, 32'h00FF0000};
        vecs[11] = '{1, 12, 32'h000000FF};
        vecs[12] = '{1, 15, 32'h00000000};
        vecs[13] = '{1, 35, 32'h00FFFF00};
        vecs[14] = '{1, 63, 32'h00000000};
        vecs[15] = '{2, 0,  32'h00FF0000};
        vecs[16] = '{2, 1,  32'h00FF0000};
        vecs[17] = '{2, 2,  32'h00000000};
        vecs[18] = '{2, 3,  32'h00000000};
        vecs[19] = '{2, 4,  32'h00FF0000};
        vecs[20] = '{2, 17, 32'h00FF0000};
        vecs[21] = '{2, 32, 32'h00000000};
        vecs[22] = '{2, 34, 32'h00FF0000};
        vecs[23] = '{2, 51, 32'h00FF0000};
        vecs[24] = '{2, 60, 32'h00000000};
        vecs[25] = '{3, 0,  32'h00000000};
        vecs[26] = '{3, 5,  32'h00050505};
        vecs[27] = '{3, 15, 32'h000F0F0F};
        vecs[28] = '{3, 47, 32'h000F0F0F};
        vecs[29] = '{3, 49, 32'h00010101};
        vecs[30] = '{1, 9,  32'h00FF00FF};
        vecs[31] = '{2, 33, 32'h00000000};
        vecs[32] = '{3, 62, 32'h000E0E0E};

        fr_chg   = '{30, 10, 50, -1};
        fr_mode  = '{2'd1, 2'd2, 2'd3, 2'd3};
        fr_color = '{24'hABCDEF, 24'hFF0000, 24'h777777, 24'h777777};

        wb.ack = 1'b1;
        wb.err = 1'b0;

        // Reset state
        repeat (3) step();
        check("rst_cyc", {31'd0, wb.cyc}, 32'd0);
        check("rst_stb", {31'd0, wb.stb}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_fdone", {31'd0, frame_done}, 32'd0);

        rst    = 1'b0;
        enable = 1'b1;
        mode   = 2'd0;
        color  = 24'h123456;

        for (int f = 0; f < 4; f++) begin
            run_frame(fr_chg[f], fr_mode[f], fr_color[f], fdd, fda, cyca);
            check($sformatf("f%0d_fdone_early", f), fdd, 32'd0);
            check($sformatf("f%0d_fdone_pulse", f), {31'd0, fda}, 32'd1);
            check($sformatf("f%0d_gap_cyc", f), {31'd0, cyca}, 32'd0);
            check_frame(f);
        end

        // Stop, then stall and err inside the first burst of a new frame (ramp mode)
        enable = 1'b0;
        step();
        check("fdone_one_cycle", {31'd0, frame_done}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);
        wb.ack = 1'b0;
        enable = 1'b1;
        step();
        check("s_b0_adr", wb.adr, 32'h1000);
        wb.ack = 1'b1;
        step();
        check("s_b1_adr", wb.adr, 32'h1004);
        step();
        check("s_b2_adr", wb.adr, 32'h1008);
        wb.ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("stall%0d_adr", k), wb.adr, 32'h1008);
            check($sformatf("stall%0d_dat", k), wb.dat_ms, 32'h00020202);
        end
        wb.ack = 1'b1;
        wb.err = 1'b1;
        step();
        check("err_adr", wb.adr, 32'h1008);
        check("err_cti", {29'd0, wb.cti}, 32'd2);
        wb.err = 1'b0;
        step();
        check("post_err_adr", wb.adr, 32'h100C);
        check("post_err_cti", {29'd0, wb.cti}, 32'd7);
        step();
        check("post_err_gap", {31'd0, wb.cyc}, 32'd0);

        // Drop enable mid-burst: burst finishes, then idle, resume at stored position
        guard = 0;
        while (!(wb.cyc && wb.adr == 32'h1024) && guard < 20) begin
            step();
            guard++;
        end
        check("reach_1024", {31'd0, wb.cyc}, 32'd1);
        enable = 1'b0;
        step();
        check("drop_adr1", wb.adr, 32'h1028);
        step();
        check("drop_adr2", wb.adr, 32'h102C);
        check("drop_cti", {29'd0, wb.cti}, 32'd7);
        step();
        check("drop_gap_cyc", {31'd0, wb.cyc}, 32'd0);
        step();
        check("drop_idle_busy", {31'd0, busy}, 32'd0);
        step();
        check("drop_idle_cyc", {31'd0, wb.cyc}, 32'd0);
        enable = 1'b1;
        step();
        check("resume_adr", wb.adr, 32'h1030);
        check("resume_dat", wb.dat_ms, 32'h000C0C0C);

        // Reset mid-burst on beat 2
        step();
        step();
        check("pre_rst_adr", wb.adr, 32'h1038);
        rst = 1'b1;
        step();
        check("rst_mid_cyc", {31'd0, wb.cyc}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        mode  = 2'd0;
        color = 24'h5A5A5A;
        step();
        check("rst_hold_cyc", {31'd0, wb.cyc}, 32'd0);
        check("rst_hold_fdone", {31'd0, frame_done}, 32'd0);
        rst = 1'b0;
        step();
        check("restart_cyc", {31'd0, wb.cyc}, 32'd1);
        check("restart_adr", wb.adr, 32'h1000);
        check("restart_dat", wb.dat_ms, 32'h005A5A5A);
        check("restart_cti", {29'd0, wb.cti}, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
